// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - per-PE result capture for one systolic row, drained in PE order
// Each PE's result is final after k_len done pulses; results stream out once every PE is captured.
module pe_result_collector #(
  parameter int NUM_PE = 4,
  parameter int RES_W  = 65,
  localparam int IDX_W = $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             k_len,
  input  logic [NUM_PE-1:0]       done_pe,
  input  logic [NUM_PE*RES_W-1:0] pe_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    round_done,
  output logic                    ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       k_lat;
  logic [15:0]       cnt    [NUM_PE];
  logic [RES_W-1:0]  buffer [NUM_PE];
  logic [NUM_PE-1:0] captured;
  logic [NUM_PE-1:0] cap_now;
  logic              bad_pulse;
  logic              all_cap;
  logic              accept_start;
  logic              handshake;

  // A pulse is only legal in ACCUM on a PE that has not yet reached k_len.
  always_comb begin
    cap_now   = '0;
    bad_pulse = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (done_pe[i]) begin
        if (state == ACCUM && !captured[i]) begin
          cap_now[i] = ((cnt[i] + 16'd1) == k_lat);
        end else begin
          bad_pulse = 1'b1;
        end
      end
    end
  end

  assign all_cap      = &(captured | cap_now);
  assign accept_start = (state == IDLE) && start && (k_len != 16'd0);
  assign handshake    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (all_cap) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_last  = (state == DRAIN) && (out_idx == LAST_IDX);
    out_data  = buffer[out_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_lat      <= '0;
      captured   <= '0;
      out_idx    <= '0;
      round_done <= 1'b0;
      ovf        <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        cnt[i]    <= '0;
        buffer[i] <= '0;
      end
    end else begin
      round_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_start) begin
            k_lat    <= k_len;
            captured <= '0;
            out_idx  <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
              cnt[i] <= '0;
            end
          end else if (start) begin
            ovf <= 1'b1;
          end
        end
        ACCUM: begin
          for (int i = 0; i < NUM_PE; i++) begin
            if (done_pe[i] && !captured[i]) begin
              cnt[i] <= cnt[i] + 16'd1;
              if (cap_now[i]) begin
                buffer[i]   <= pe_result[i*RES_W +: RES_W];
                captured[i] <= 1'b1;
              end
            end
          end
          if (all_cap) begin
            out_idx <= '0;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (out_last) begin
              out_idx    <= '0;
              round_done <= 1'b1;
            end else begin
              out_idx <= out_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
      // Unexpected pulses win over a same-cycle clear so they are never lost.
      if (bad_pulse) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - randomized self-checking bench for pe_result_collector
module tb_pe_result_collector;
  localparam int NUM_PE = 4;
  localparam int RES_W  = 65;
  localparam int IDX_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic [15:0]             k_len = '0;
  logic [NUM_PE-1:0]       done_pe = '0;
  logic [NUM_PE*RES_W-1:0] pe_result = '0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic [RES_W-1:0]        out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    busy;
  logic                    round_done;
  logic                    ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 accumulating, 2 draining
  int               m_state;
  int               m_k;
  int               m_cnt [NUM_PE];
  logic [RES_W-1:0] m_val [NUM_PE];
  bit               m_ovf;

  pe_result_collector #(.NUM_PE(NUM_PE), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .done_pe(done_pe),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .round_done(round_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RES_W-1:0] rand_res();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[RES_W-1:0];
  endfunction

  function automatic logic [NUM_PE*RES_W-1:0] rand_vec();
    logic [NUM_PE*RES_W-1:0] r;
    for (int i = 0; i < NUM_PE; i++) r[i*RES_W +: RES_W] = rand_res();
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_ovf = 0;
    for (int i = 0; i < NUM_PE; i++) begin m_cnt[i] = 0; m_val[i] = '0; end
  endtask

  task automatic do_start(input logic [15:0] k);
    start = 1'b1; k_len = k;
    tick();
    start = 1'b0;
    if (m_state == 0) begin
      if (k != 16'd0) begin
        m_state = 1; m_k = int'(k); m_ovf = 0;
        for (int i = 0; i < NUM_PE; i++) m_cnt[i] = 0;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic pulse(input logic [NUM_PE-1:0] mask, input logic [NUM_PE*RES_W-1:0] res);
    bit all;
    done_pe = mask; pe_result = res;
    for (int i = 0; i < NUM_PE; i++) begin
      if (mask[i]) begin
        if (m_state == 1 && m_cnt[i] < m_k) begin
          m_cnt[i]++;
          if (m_cnt[i] == m_k) m_val[i] = res[i*RES_W +: RES_W];
        end else begin
          m_ovf = 1;
        end
      end
    end
    tick();
    done_pe = '0;
    if (m_state == 1) begin
      all = 1;
      for (int i = 0; i < NUM_PE; i++) if (m_cnt[i] < m_k) all = 0;
      if (all) m_state = 2;
    end
  endtask

  task automatic random_accum();
    int cyc;
    cyc = 0;
    while (m_state == 1 && cyc < 300) begin
      pulse(NUM_PE'($urandom_range(0, 15)), rand_vec());
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0h exp 0", out_last); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_out_idx got %0h exp 0", out_idx); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL reset_round_done got %0h exp 0", round_done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", ovf); end
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    logic [NUM_PE*RES_W-1:0] v;
    do_start(16'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", busy); end
    pulse(4'hF, rand_vec());
    pulse(4'hF, rand_vec());
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0h exp 0", out_valid); end
    for (int i = 0; i < NUM_PE; i++) v[i*RES_W +: RES_W] = RES_W'(10 + i);
    pulse(4'hF, v);
    out_ready = 1'b1;
    for (int j = 0; j < NUM_PE; j++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid j=%0d got %0h exp 1", j, out_valid); end
      checks++; if (out_idx !== IDX_W'(j)) begin errors++; $display("FAIL basic_idx got %0h exp %0h", out_idx, j); end
      checks++; if (out_data !== RES_W'(10 + j)) begin errors++; $display("FAIL basic_data got %0h exp %0h", out_data, 10 + j); end
      checks++; if (out_last !== (j == NUM_PE - 1)) begin errors++; $display("FAIL basic_last j=%0d got %0h", j, out_last); end
      tick();
    end
    m_state = 0;
    checks++; if (round_done !== 1'b1) begin errors++; $display("FAIL basic_round_done got %0h exp 1", round_done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %0h exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0h exp 0", busy); end
    tick();
    checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL basic_round_done_pulse got %0h exp 0", round_done); end
    out_ready = 1'b0;
  endtask

  task automatic test_staggered();
    logic [NUM_PE*RES_W-1:0] v;
    do_start(16'd2);
    pulse(4'b0011, rand_vec());
    pulse(4'b0100, rand_vec());
    pulse(4'b0011, rand_vec());
    pulse(4'b0100, rand_vec());
    pulse(4'b1000, rand_vec());
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stag_early_valid got %0h exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stag_gap_valid got %0h exp 0", out_valid); end
    v = rand_vec();
    v[3*RES_W +: RES_W] = 65'h1_0000_0000_0000_0000;
    pulse(4'b1000, v);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stag_valid got %0h exp 1", out_valid); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL stag_idx0 got %0h exp 0", out_idx); end
    out_ready = 1'b1;
    for (int j = 0; j < NUM_PE; j++) begin
      checks++; if (out_data !== m_val[j]) begin errors++; $display("FAIL stag_data j=%0d got %0h exp %0h", j, out_data, m_val[j]); end
      if (j == NUM_PE - 1) begin
        checks++; if (out_data !== 65'h1_0000_0000_0000_0000) begin errors++; $display("FAIL stag_wide got %0h exp 10000000000000000", out_data); end
      end
      tick();
    end
    m_state = 0;
    checks++; if (round_done !== 1'b1) begin errors++; $display("FAIL stag_round_done got %0h exp 1", round_done); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_start(16'($urandom_range(1, 4)));
    random_accum();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0h exp 1", out_valid); end
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL bp_ovf got %0h exp %0h", ovf, m_ovf); end
    out_ready = 1'b1;
    checks++; if (out_data !== m_val[0]) begin errors++; $display("FAIL bp_data0 got %0h exp %0h", out_data, m_val[0]); end
    tick();
    out_ready = 1'b0;
    repeat (5) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0h exp 1", out_valid); end
      checks++; if (out_idx !== IDX_W'(1)) begin errors++; $display("FAIL bp_hold_idx got %0h exp 1", out_idx); end
      checks++; if (out_data !== m_val[1]) begin errors++; $display("FAIL bp_hold_data got %0h exp %0h", out_data, m_val[1]); end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 1; j < NUM_PE; j++) begin
      checks++; if (out_idx !== IDX_W'(j)) begin errors++; $display("FAIL bp_idx got %0h exp %0h", out_idx, j); end
      checks++; if (out_data !== m_val[j]) begin errors++; $display("FAIL bp_data j=%0d got %0h exp %0h", j, out_data, m_val[j]); end
      tick();
    end
    m_state = 0;
    checks++; if (round_done !== 1'b1) begin errors++; $display("FAIL bp_round_done got %0h exp 1", round_done); end
    out_ready = 1'b0;
  endtask

  task automatic test_ovf();
    logic [NUM_PE*RES_W-1:0] v;
    logic [RES_W-1:0]        a;
    do_start(16'd1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_start_clear got %0h exp 0", ovf); end
    v = rand_vec();
    a = v[RES_W-1:0];
    pulse(4'b0001, v);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_legal got %0h exp 0", ovf); end
    pulse(4'b0001, rand_vec());
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_extra got %0h exp 1", ovf); end
    pulse(4'b1110, rand_vec());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0h exp 1", out_valid); end
    checks++; if (out_data !== a) begin errors++; $display("FAIL ovf_kept got %0h exp %0h", out_data, a); end
    out_ready = 1'b1;
    repeat (NUM_PE) tick();
    out_ready = 1'b0;
    m_state = 0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h exp 1", ovf); end
    do_start(16'd1);
    pulse(4'hF, rand_vec());
    out_ready = 1'b1;
    repeat (NUM_PE) tick();
    out_ready = 1'b0;
    m_state = 0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clean_round got %0h exp 0", ovf); end
    pulse(4'b0001, rand_vec());
    checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL ovf_idle_pulse got %0h exp %0h", ovf, m_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle_busy got %0h exp 0", busy); end
  endtask

  task automatic test_start_rules();
    do_start(16'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k0_busy got %0h exp 0", busy); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL k0_ovf got %0h exp 1", ovf); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k0_stay_idle got %0h exp 0", busy); end
    do_start(16'd2);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL k2_ovf_clear got %0h exp 0", ovf); end
    pulse(4'hF, rand_vec());
    do_start(16'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accum_start_busy got %0h exp 1", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL accum_start_ovf got %0h exp 0", ovf); end
    pulse(4'hF, rand_vec());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL accum_start_klen got %0h exp 1", out_valid); end
    out_ready = 1'b1;
    for (int j = 0; j < NUM_PE; j++) begin
      checks++; if (out_data !== m_val[j]) begin errors++; $display("FAIL accum_start_data j=%0d got %0h exp %0h", j, out_data, m_val[j]); end
      tick();
    end
    out_ready = 1'b0;
    m_state = 0;
  endtask

  task automatic test_reset_mid_drain();
    do_start(16'd1);
    pulse(4'hF, rand_vec());
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checks++; if (out_idx !== IDX_W'(2)) begin errors++; $display("FAIL rst_pre_idx got %0h exp 2", out_idx); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0h exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %0h exp 0", busy); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL rst_async_idx got %0h exp 0", out_idx); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_async_data got %0h exp 0", out_data); end
    #3;
    rst = 1'b1;
    model_reset();
    tick();
    do_start(16'd2);
    pulse(4'hF, rand_vec());
    pulse(4'hF, rand_vec());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_new_valid got %0h exp 1", out_valid); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL rst_new_idx got %0h exp 0", out_idx); end
    checks++; if (out_data !== m_val[0]) begin errors++; $display("FAIL rst_new_data got %0h exp %0h", out_data, m_val[0]); end
    out_ready = 1'b1;
    repeat (NUM_PE) tick();
    out_ready = 1'b0;
    m_state = 0;
  endtask

  task automatic test_random();
    int idx;
    int cyc;
    bit hs;
    for (int r = 0; r < 8; r++) begin
      do_start(16'($urandom_range(1, 5)));
      random_accum();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_enter_drain r=%0d got %0h exp 1", r, out_valid); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf r=%0d got %0h exp %0h", r, ovf, m_ovf); end
      idx = 0;
      cyc = 0;
      while (idx < NUM_PE && cyc < 400) begin
        out_ready = 1'($urandom_range(0, 1));
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_valid got %0h exp 1", out_valid); end
        checks++; if (out_idx !== IDX_W'(idx)) begin errors++; $display("FAIL rand_idx got %0h exp %0h", out_idx, idx); end
        checks++; if (out_data !== m_val[idx]) begin errors++; $display("FAIL rand_data got %0h exp %0h", out_data, m_val[idx]); end
        checks++; if (out_last !== (idx == NUM_PE - 1)) begin errors++; $display("FAIL rand_last got %0h idx %0d", out_last, idx); end
        hs = out_ready;
        tick();
        cyc++;
        if (hs) idx++;
      end
      checks++; if (idx != NUM_PE) begin errors++; $display("FAIL rand_drain_timeout got %0d exp %0d", idx, NUM_PE); end
      checks++; if (round_done !== 1'b1) begin errors++; $display("FAIL rand_round_done got %0h exp 1", round_done); end
      out_ready = 1'b0;
      m_state = 0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_staggered();
    test_backpressure();
    test_ovf();
    test_start_rules();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_result_collector.md
PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning the number of PEs in one systolic row (2..16).
REQ-002 SHALL have parameter RES_W, default 65, meaning the width of each PE accumulated result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a single-cycle request that begins a collection round.
REQ-006 SHALL have port k_len, input, 16, the number of done_pe pulses per PE that make a result final; sampled on start.
REQ-007 SHALL have port done_pe, input, NUM_PE, the per-PE accumulate-done pulses.
REQ-008 SHALL have port pe_result, input, NUM_PE*RES_W, the flattened PE accumulators, with PE i at bits [i*RES_W +: RES_W].
REQ-009 SHALL have port out_valid, output, 1, asserted when out_data holds a final result.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 SHALL have port out_data, output, RES_W, the final result of PE out_idx.
REQ-012 SHALL have port out_idx, output, clog2(NUM_PE), the PE index of out_data.
REQ-013 SHALL have port out_last, output, 1, high with out_valid when out_idx = NUM_PE-1.
REQ-014 SHALL have port busy, output, 1, high in ACCUM and DRAIN.
REQ-015 SHALL have port round_done, output, 1, a one-cycle pulse after the last result is accepted.
REQ-016 SHALL have port ovf, output, 1, a sticky flag for unexpected done_pe pulses.

Function
REQ-017 SHALL implement the states IDLE, ACCUM and DRAIN.
REQ-018 SHALL, in IDLE with start=1 and k_len≠0, latch k_len, clear all per-PE counters and captured flags, and enter ACCUM at the next edge.
REQ-019 SHALL, when start=1 with k_len=0, remain in IDLE and set ovf.
REQ-020 SHALL ignore start outside IDLE with no other effect.
REQ-021 SHALL, in ACCUM, increment a 16-bit per-PE counter on each sampled done_pe[i]=1.
REQ-022 SHALL, on the done_pe[i] pulse that takes counter i to k_len, capture pe_result slice i into buffer i in that same edge and set captured[i].
REQ-023 SHALL treat simultaneous done_pe pulses on several PEs independently within the same cycle.
REQ-024 SHALL, when the last captured bit becomes set, enter DRAIN at that same edge, so out_valid=1, out_idx=0 in the next cycle.
REQ-025 SHALL, in DRAIN, hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on out_valid&out_ready, advance out_idx by one, with one result per cycle under continuous ready.
REQ-027 SHALL, on the handshake with out_last=1, return to IDLE, deassert out_valid, and pulse round_done for one cycle.
REQ-028 SHALL, on done_pe[i] while captured[i]=1, or on any done_pe in IDLE or DRAIN, ignore the pulse, leave the buffer unchanged, and set ovf.
REQ-029 SHALL clear ovf only by reset or by an accepted start (k_len≠0).
REQ-030 SHALL make out_data equal buffer[out_idx] with no arithmetic or truncation (RES_W bits).

Reset
REQ-031 SHALL, on rst=0 at any time including mid-ACCUM or mid-DRAIN, enter IDLE asynchronously.
REQ-032 SHALL, during reset, drive out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, round_done=0 and ovf=0, and clear the counters, captured flags and buffers.
REQ-033 SHALL resume operation on the first rising clk edge after rst deasserts; any partial round is discarded.

Verification
REQ-034 SHALL cover: NUM_PE=4, start with k_len=3, three done_pe=4'b1111 pulses with PE i result = 10+i on the third pulse, out_ready=1 -> outputs 10,11,12,13 on consecutive cycles with idx 0..3, out_last on 13, round_done the cycle after.
REQ-035 SHALL cover: k_len=2 with staggered pulses (PE3 last, result 0x1_0000_0000_0000_0000) -> out_valid one cycle after PE3's second pulse edge, full 65-bit value exact.
REQ-036 SHALL cover: DRAIN with out_ready held 0 for 5 cycles at idx 1 -> out_data and out_idx unchanged; the stream completes once ready rises.
REQ-037 SHALL cover: an extra done_pe[0] after capture, plus done_pe in IDLE -> ovf=1, captured value unchanged; the next start clears ovf.
REQ-038 SHALL cover: start with k_len=0 -> stays IDLE, busy=0, ovf=1; start during ACCUM -> ignored.
REQ-039 SHALL cover: rst low mid-DRAIN at idx 2 -> out_valid=0 immediately (asynchronous), busy=0; a new round after release starts at idx 0.
